uart_rx: RTL and testbench

Receive half of the mini-UART: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from an asynchronous serial line and presents each byte with a one-cycle valid strobe. It pairs with `uart_tx` at the far end of the same link, uses the same `CLK_CYCLES`/`BAUD_RATE` parameterisation, and feeds the host-side logic directly (no FIFO).

---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling, valid and framing-error strobes
module uart_rx #(
    parameter int CLK_CYCLES = 100_000_000,
    parameter int BAUD_RATE  = 19200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_err_o,
    output logic       is_receiving_o
);

    localparam int BAUD_CYCLES = CLK_CYCLES / BAUD_RATE;
    localparam int HALF_CYCLES = BAUD_CYCLES / 2;
    localparam int TW          = $clog2(BAUD_CYCLES) + 1;

    // The timer samples on the cycle it reads zero, so loads are one short of the interval.
    localparam logic [TW-1:0] BAUD_LOAD = TW'(BAUD_CYCLES - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    typedef enum logic [2:0] {
        RX_WAIT_IDLE,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } state_t;

    state_t          state_q, state_n;
    logic [TW-1:0]   timer_q, timer_n;
    logic [2:0]      bit_cnt_q, bit_cnt_n;
    logic [7:0]      shift_q, shift_n;
    logic [7:0]      byte_q, byte_n;
    logic            valid_q, valid_n;
    logic            err_q, err_n;
    logic            rx_meta, rx_s;
    logic            tick;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // State, timer, shift register and registered output strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RX_WAIT_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            bit_cnt_q <= bit_cnt_n;
            shift_q   <= shift_n;
            byte_q    <= byte_n;
            valid_q   <= valid_n;
            err_q     <= err_n;
        end
    end

    assign tick = (timer_q == '0);

    // Next-state logic: hunt for start, confirm at half bit, sample data and stop at bit centres.
    always_comb begin
        state_n   = state_q;
        timer_n   = tick ? timer_q : (timer_q - TIMER_ONE);
        bit_cnt_n = bit_cnt_q;
        shift_n   = shift_q;
        byte_n    = byte_q;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        unique case (state_q)
            RX_WAIT_IDLE: begin
                if (rx_s) state_n = RX_IDLE;
            end
            RX_IDLE: begin
                if (!rx_s) begin
                    timer_n = HALF_LOAD;
                    state_n = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        bit_cnt_n = 3'd0;
                        timer_n   = BAUD_LOAD;
                        state_n   = RX_DATA;
                    end else begin
                        state_n = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shift_n   = {rx_s, shift_q[7:1]};
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    timer_n   = BAUD_LOAD;
                    if (bit_cnt_q == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        byte_n  = shift_q;
                        valid_n = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = RX_WAIT_IDLE;
                    end
                end
            end
            default: state_n = RX_WAIT_IDLE;
        endcase
    end

    assign rx_byte_o      = byte_q;
    assign rx_valid_o     = valid_q;
    assign rx_err_o       = err_q;
    assign is_receiving_o = (state_q == RX_START) || (state_q == RX_DATA) || (state_q == RX_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int B = 100;
    localparam int H = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       is_rcv;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         err_cnt = 0;
    int         both_cnt = 0;
    int         rcv_cnt = 0;

    uart_rx #(.CLK_CYCLES(1_920_000), .BAUD_RATE(19200)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_i           (rx),
        .rx_byte_o      (rx_byte),
        .rx_valid_o     (rx_valid),
        .rx_err_o       (rx_err),
        .is_receiving_o (is_rcv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_byte);
            got_cyc.push_back(cyc);
        end
        if (rx_err) err_cnt <= err_cnt + 1;
        if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
        if (is_rcv) rcv_cnt <= rcv_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_bit);
        rx = 1'b0;
        idle(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bc);
        end
        rx = stop_bit;
        idle(bc);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        idle(4);
        vectors += 4;
        if (rx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        if (rx_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", rx_err); end
        if (is_rcv !== 1'b0) begin miscompares++; $display("FAIL reset_rcv: got %b want 0", is_rcv); end
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_single;
        int base, ebase, t_fall, lat;
        base = got_q.size();
        ebase = err_cnt;
        t_fall = cyc;
        send_frame(8'hA5, B, 1'b1);
        idle(2 * B);
        vectors += 3;
        if (got_q.size() - base !== 1) begin
            miscompares++; $display("FAIL single_count: got %0d want 1", got_q.size() - base);
        end else begin
            if (got_q[base] !== 8'hA5) begin miscompares++; $display("FAIL single_byte: got %h want a5", got_q[base]); end
            lat = got_cyc[base] - t_fall;
            vectors++;
            if (lat < H + 9 * B + 2 || lat > H + 9 * B + 3) begin
                miscompares++; $display("FAIL single_latency: got %0d want %0d..%0d", lat, H + 9 * B + 2, H + 9 * B + 3);
            end
        end
        if (err_cnt - ebase !== 0) begin miscompares++; $display("FAIL single_err: got %0d want 0", err_cnt - ebase); end
    endtask

    task automatic test_back_to_back;
        int base, ebase;
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        base = got_q.size();
        ebase = err_cnt;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], B, 1'b1);
        idle(2 * B);
        vectors += 2;
        if (got_q.size() - base !== 3) begin
            miscompares++; $display("FAIL b2b_count: got %0d want 3", got_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got_q[base + i] !== exp_b[i]) begin
                    miscompares++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[base + i], exp_b[i]);
                end
            end
        end
        if (err_cnt - ebase !== 0) begin miscompares++; $display("FAIL b2b_err: got %0d want 0", err_cnt - ebase); end
    endtask

    task automatic test_glitch;
        int base, ebase, rbase;
        base = got_q.size();
        ebase = err_cnt;
        rbase = rcv_cnt;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(3 * B);
        vectors += 4;
        if (got_q.size() - base !== 0) begin miscompares++; $display("FAIL glitch_valid: got %0d want 0", got_q.size() - base); end
        if (err_cnt - ebase !== 0) begin miscompares++; $display("FAIL glitch_err: got %0d want 0", err_cnt - ebase); end
        if (rcv_cnt - rbase !== H) begin miscompares++; $display("FAIL glitch_rcv_cycles: got %0d want %0d", rcv_cnt - rbase, H); end
        if (is_rcv !== 1'b0) begin miscompares++; $display("FAIL glitch_rcv_end: got %b want 0", is_rcv); end
    endtask

    task automatic test_framing;
        int base, ebase;
        base = got_q.size();
        ebase = err_cnt;
        send_frame(8'h3C, B, 1'b0);
        rx = 1'b0;
        idle(3 * B);
        vectors += 4;
        if (err_cnt - ebase !== 1) begin miscompares++; $display("FAIL frame_err_count: got %0d want 1", err_cnt - ebase); end
        if (got_q.size() - base !== 0) begin miscompares++; $display("FAIL frame_valid: got %0d want 0", got_q.size() - base); end
        if (rx_byte !== 8'h55) begin miscompares++; $display("FAIL frame_byte_held: got %h want 55", rx_byte); end
        if (is_rcv !== 1'b0) begin miscompares++; $display("FAIL frame_rcv_low_line: got %b want 0", is_rcv); end
        rx = 1'b1;
        idle(2 * B);
        send_frame(8'h81, B, 1'b1);
        idle(2 * B);
        vectors += 2;
        if (got_q.size() - base !== 1) begin
            miscompares++; $display("FAIL frame_next_count: got %0d want 1", got_q.size() - base);
        end else if (got_q[base] !== 8'h81) begin
            miscompares++; $display("FAIL frame_next_byte: got %h want 81", got_q[base]);
        end
        if (err_cnt - ebase !== 1) begin miscompares++; $display("FAIL frame_next_err: got %0d want 1", err_cnt - ebase); end
    endtask

    task automatic test_reset_midframe;
        int base, ebase;
        logic [7:0] b;
        b = 8'hF5;
        base = got_q.size();
        ebase = err_cnt;
        rx = 1'b0;
        idle(B);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            idle(B);
        end
        rx = b[4];
        idle(B / 2);
        rst = 1'b1;
        idle(3);
        vectors += 4;
        if (rx_byte !== 8'h00) begin miscompares++; $display("FAIL midrst_byte: got %h want 00", rx_byte); end
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
        if (rx_err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b want 0", rx_err); end
        if (is_rcv !== 1'b0) begin miscompares++; $display("FAIL midrst_rcv: got %b want 0", is_rcv); end
        rst = 1'b0;
        idle(B / 2 - 3);
        for (int i = 5; i < 8; i++) begin
            rx = b[i];
            idle(B);
        end
        rx = 1'b1;
        idle(2 * B);
        vectors += 2;
        if (got_q.size() - base !== 0) begin miscompares++; $display("FAIL midrst_pulses: got %0d want 0", got_q.size() - base); end
        if (err_cnt - ebase !== 0) begin miscompares++; $display("FAIL midrst_errs: got %0d want 0", err_cnt - ebase); end
        send_frame(8'h7E, B, 1'b1);
        idle(2 * B);
        vectors++;
        if (got_q.size() - base !== 1) begin
            miscompares++; $display("FAIL midrst_next_count: got %0d want 1", got_q.size() - base);
        end else begin
            vectors++;
            if (got_q[base] !== 8'h7E) begin miscompares++; $display("FAIL midrst_next_byte: got %h want 7e", got_q[base]); end
        end
    endtask

    task automatic test_skew;
        int base, ebase;
        int rates[2];
        rates[0] = 97; rates[1] = 103;
        for (int r = 0; r < 2; r++) begin
            base = got_q.size();
            ebase = err_cnt;
            send_frame(8'hC3, rates[r], 1'b1);
            idle(2 * B);
            vectors += 2;
            if (got_q.size() - base !== 1) begin
                miscompares++; $display("FAIL skew%0d_count: got %0d want 1", rates[r], got_q.size() - base);
            end else if (got_q[base] !== 8'hC3) begin
                miscompares++; $display("FAIL skew%0d_byte: got %h want c3", rates[r], got_q[base]);
            end
            if (err_cnt - ebase !== 0) begin miscompares++; $display("FAIL skew%0d_err: got %0d want 0", rates[r], err_cnt - ebase); end
        end
    endtask

    task automatic test_exclusive;
        vectors++;
        if (both_cnt !== 0) begin miscompares++; $display("FAIL valid_err_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_framing;
        test_reset_midframe;
        test_skew;
        test_exclusive;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
